// File: rtl/regbank_pkg.sv
// Shared types and defaults for the burst-arbitrated register bank.
// State encoding is fixed so the two grant bits map directly onto state bits.
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_NREG      = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/regbank_dffs.sv
// NREG x DWIDTH flop bank: one synchronous write port, one combinational read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module regbank_dffs
    import regbank_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int NREG   = DEF_NREG,
    parameter int AWIDTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] regs_q [NREG];
    logic              waddr_ok;
    logic              raddr_ok;

    assign waddr_ok = (32'(i_waddr) < NREG);
    assign raddr_ok = (32'(i_raddr) < NREG);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_we && waddr_ok) begin
            regs_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = raddr_ok ? regs_q[i_raddr] : '0;

endmodule

// File: rtl/regbank_burst_arbiter.sv
// Round-robin arbiter giving two writers bounded bursts into a shared flop bank.
// Grant is registered: a request seen in IDLE is granted the next cycle.
module regbank_burst_arbiter
    import regbank_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int NREG      = DEF_NREG,
    parameter int AWIDTH    = 2,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req0,
    input  logic [AWIDTH-1:0] i_addr0,
    input  logic [DWIDTH-1:0] i_data0,
    output logic              o_gnt0,
    input  logic              i_req1,
    input  logic [AWIDTH-1:0] i_addr1,
    input  logic [DWIDTH-1:0] i_data1,
    output logic              o_gnt1,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_busy
);

    localparam int CWIDTH = $clog2(MAX_BURST) + 1;
    localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              gnt0_q, gnt1_q, busy_q;

    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    // Writes are gated by the registered state, so a grant always precedes its first write.
    assign wr_en   = ((state_q == OWN0) && i_req0) || ((state_q == OWN1) && i_req1);
    assign wr_addr = (state_q == OWN1) ? i_addr1 : i_addr0;
    assign wr_data = (state_q == OWN1) ? i_data1 : i_data0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_req0 && i_req1) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (i_req0) begin
                    state_d = OWN0;
                end else if (i_req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (i_req0) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (i_req1) begin
                            state_d = OWN1;
                            prio_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CWIDTH'(1);
                    end
                end else begin
                    // Owner went quiet: hand over immediately, or park in IDLE.
                    cnt_d   = '0;
                    prio_d  = 1'b1;
                    state_d = i_req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (i_req1) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (i_req0) begin
                            state_d = OWN0;
                            prio_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CWIDTH'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    prio_d  = 1'b0;
                    state_d = i_req0 ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_gnt0 = gnt0_q;
    assign o_gnt1 = gnt1_q;
    assign o_busy = busy_q;

    regbank_dffs #(
        .DWIDTH (DWIDTH),
        .NREG   (NREG),
        .AWIDTH (AWIDTH)
    ) u_dffs (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (i_raddr),
        .o_rdata (o_rdata)
    );

endmodule

// File: tb/tb_regbank_burst_arbiter.sv
// Directed bench for regbank_burst_arbiter: default config, a 3-register bank
// and a MAX_BURST=1 variant, all driven from the same input vectors.
module tb_regbank_burst_arbiter;

    logic       clk;
    logic       rstn;
    logic       req0, req1;
    logic [1:0] addr0, addr1, raddr;
    logic [7:0] data0, data1;

    logic       gnt0, gnt1, busy;
    logic [7:0] rdata;
    logic       gnt0_b, gnt1_b, busy_b;
    logic [7:0] rdata_b;
    logic       gnt0_m, gnt1_m, busy_m;
    logic [7:0] rdata_m;

    int n_checks = 0;
    int n_errors = 0;

    regbank_burst_arbiter #(.DWIDTH(8), .NREG(4), .AWIDTH(2), .MAX_BURST(4)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_gnt0(gnt0),
        .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_gnt1(gnt1),
        .i_raddr(raddr), .o_rdata(rdata), .o_busy(busy)
    );

    regbank_burst_arbiter #(.DWIDTH(8), .NREG(3), .AWIDTH(2), .MAX_BURST(4)) u_dut_n3 (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_gnt0(gnt0_b),
        .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_gnt1(gnt1_b),
        .i_raddr(raddr), .o_rdata(rdata_b), .o_busy(busy_b)
    );

    regbank_burst_arbiter #(.DWIDTH(8), .NREG(4), .AWIDTH(2), .MAX_BURST(1)) u_dut_mb1 (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_gnt0(gnt0_m),
        .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_gnt1(gnt1_m),
        .i_raddr(raddr), .o_rdata(rdata_m), .o_busy(busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        raddr = a;
        #1;
        check(tag, {24'h0, rdata}, {24'h0, exp});
    endtask

    task automatic rd_n3(input string tag, input logic [1:0] a, input logic [7:0] exp);
        raddr = a;
        #1;
        check(tag, {24'h0, rdata_b}, {24'h0, exp});
    endtask

    initial begin
        rstn = 1'b0; req0 = 1'b1; req1 = 1'b1;
        addr0 = 2'd0; addr1 = 2'd0; data0 = 8'h00; data1 = 8'h00; raddr = 2'd0;

        // Reset held two cycles with both requests high
        step();
        step();
        check("rst_gnt0", {31'h0, gnt0}, 0);
        check("rst_gnt1", {31'h0, gnt1}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        for (int i = 0; i < 4; i++) rd($sformatf("rst_reg%0d", i), 2'(i), 8'h00);

        // Single requester latency
        rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
        step();
        check("single_gnt0", {31'h0, gnt0}, 1);
        check("single_busy", {31'h0, busy}, 1);
        rd("single_old", 2'd2, 8'h00);
        step();
        req0 = 1'b0;
        rd("single_new", 2'd2, 8'hA5);
        step();
        check("single_idle", {31'h0, busy}, 0);

        // Simultaneous start after reset: owner 0 first, four writes each
        rstn = 1'b0;
        step();
        rstn = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 2'd0; data0 = 8'h10;
        step();
        check("sim_first_gnt0", {31'h0, gnt0}, 1);
        check("sim_first_gnt1", {31'h0, gnt1}, 0);
        for (int i = 0; i < 4; i++) begin
            addr0 = 2'(i); data0 = 8'h10 + 8'(i);
            check($sformatf("burst0_gnt_w%0d", i), {31'h0, gnt0}, 1);
            step();
        end
        check("handover_gnt1", {31'h0, gnt1}, 1);
        check("handover_gnt0", {31'h0, gnt0}, 0);
        for (int i = 0; i < 4; i++) rd($sformatf("burst0_reg%0d", i), 2'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            addr1 = 2'(i); data1 = 8'h20 + 8'(i);
            check($sformatf("burst1_gnt_w%0d", i), {31'h0, gnt1}, 1);
            step();
        end
        check("return_gnt0", {31'h0, gnt0}, 1);
        for (int i = 0; i < 4; i++) rd($sformatf("burst1_reg%0d", i), 2'(i), 8'h20 + 8'(i));

        // Early release by owner 1 after two writes
        req0 = 1'b0;
        step();
        check("early_gnt1", {31'h0, gnt1}, 1);
        addr1 = 2'd0; data1 = 8'h30;
        step();
        addr1 = 2'd1; data1 = 8'h31;
        step();
        req1 = 1'b0; data1 = 8'h99;
        check("early_idle_grant", {31'h0, gnt1}, 1);
        step();
        check("early_gnt1_off", {31'h0, gnt1}, 0);
        check("early_busy_off", {31'h0, busy}, 0);
        rd("early_reg0", 2'd0, 8'h30);
        rd("early_reg1", 2'd1, 8'h31);
        rd("early_reg2", 2'd2, 8'h22);
        req0 = 1'b1; req1 = 1'b1;
        step();
        check("prio_back_gnt0", {31'h0, gnt0}, 1);
        check("prio_back_gnt1", {31'h0, gnt1}, 0);

        // Reset during owner 0's third write
        addr0 = 2'd3; data0 = 8'h40;
        step();
        addr0 = 2'd2; data0 = 8'h41;
        step();
        rd("mid_reg2_pre", 2'd2, 8'h41);
        addr0 = 2'd1; data0 = 8'hFF; rstn = 1'b0;
        step();
        rd("mid_reg1", 2'd1, 8'h00);
        check("mid_gnt0", {31'h0, gnt0}, 0);
        rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        check("mid_idle", {31'h0, busy}, 0);

        // Out-of-range write on the 3-register bank; MAX_BURST=1 alternation alongside
        req0 = 1'b1; req1 = 1'b1; addr0 = 2'd3; data0 = 8'h77;
        step();
        check("oor_gnt0", {31'h0, gnt0_b}, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                addr0 = 2'(i - 1); data0 = 8'h50 + 8'(i - 1);
            end
            check($sformatf("mb1_gnt0_c%0d", i), {31'h0, gnt0_m}, (i % 2 == 0) ? 1 : 0);
            check($sformatf("mb1_gnt1_c%0d", i), {31'h0, gnt1_m}, (i % 2 == 1) ? 1 : 0);
            step();
            if (i == 0) begin
                for (int r = 0; r < 4; r++) rd_n3($sformatf("oor_reg%0d", r), 2'(r), 8'h00);
            end
        end
        check("oor_cnt_handover", {31'h0, gnt1_b}, 1);
        rd_n3("oor_reg2_final", 2'd2, 8'h52);
        rd_n3("oor_addr3_final", 2'd3, 8'h00);

        req0 = 1'b0; req1 = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
